// File: rtl/neuron_array_pif_pkg.sv
// ============================================================================
// Module   : neuron_pkg
// Purpose  : Shared types, constants and saturating arithmetic helpers for the
//            time-multiplexed integrate-and-fire neuron array.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package neuron_pkg;

   localparam int DEF_INTEGER_WIDTH   = 16;
   localparam int DEF_DATA_WIDTH_FRAC = 0;
   localparam int DEF_DATA_WIDTH      = DEF_INTEGER_WIDTH + DEF_DATA_WIDTH_FRAC;

   // Two's complement extremes of the default datapath width.
   localparam logic signed [DEF_DATA_WIDTH-1:0] DATA_MAX = {1'b0, {(DEF_DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DEF_DATA_WIDTH-1:0] DATA_MIN = {1'b1, {(DEF_DATA_WIDTH-1){1'b0}}};

   // Arithmetic is carried out in a wide signed type and then clamped, so one
   // helper serves any datapath width up to well below SAT_W bits.
   localparam int SAT_W = 64;
   typedef logic signed [SAT_W-1:0] wide_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_UPDATE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // Clamp a wide signed value into the range of a w-bit two's complement number.
   function automatic wide_t sat_clamp(input wide_t v, input int w);
      wide_t hi;
      wide_t lo;
      hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
      lo = -hi - wide_t'(1);
      if (v > hi) begin
         return hi;
      end else if (v < lo) begin
         return lo;
      end
      return v;
   endfunction

   function automatic wide_t sat_add(input wide_t a, input wide_t b, input int w);
      return sat_clamp(a + b, w);
   endfunction

   function automatic wide_t sat_sub(input wide_t a, input wide_t b, input int w);
      return sat_clamp(a - b, w);
   endfunction

endpackage

`default_nettype wire

// File: rtl/neuron_array_pif_if.sv
// ============================================================================
// Module   : neuron_array_pif_if
// Purpose  : Weight stream, update control and spike result bundle of the
//            neuron array. slave = array side, master = fetch/router side.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface neuron_array_pif_if #(
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 2,
   parameter int NUM_NEURONS = 4
);
   logic                          weightValid;
   logic [ADDR_WIDTH-1:0]         weightAddr;
   logic signed [DATA_WIDTH-1:0]  weightData;
   logic                          weightReady;
   logic                          updateEnable;
   logic signed [DATA_WIDTH-1:0]  threshold;
   logic                          resetMode;
   logic                          leakEnable;
   logic                          busy;
   logic                          spikeValid;
   logic [ADDR_WIDTH-1:0]         spikeAddr;
   logic                          spikeOut;
   logic signed [DATA_WIDTH-1:0]  vmemOut;
   logic [NUM_NEURONS-1:0]        spikeVector;
   logic                          done;

   modport slave (
      input  weightValid, weightAddr, weightData, updateEnable, threshold,
             resetMode, leakEnable,
      output weightReady, busy, spikeValid, spikeAddr, spikeOut, vmemOut,
             spikeVector, done
   );

   modport master (
      output weightValid, weightAddr, weightData, updateEnable, threshold,
             resetMode, leakEnable,
      input  weightReady, busy, spikeValid, spikeAddr, spikeOut, vmemOut,
             spikeVector, done
   );
endinterface

`default_nettype wire

// File: rtl/neuron_array_pif_update_core.sv
// ============================================================================
// Module   : pif_update_core
// Purpose  : Combinational single-neuron step: optional leak, saturating
//            integrate, threshold compare and membrane reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pif_update_core
   import neuron_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int LEAK_SHIFT = 4
) (
   input  logic signed [DATA_WIDTH-1:0] i_vmem,
   input  logic signed [DATA_WIDTH-1:0] i_weight_sum,
   input  logic signed [DATA_WIDTH-1:0] i_threshold,
   input  logic                         i_leak_enable,
   input  logic                         i_reset_mode,
   output logic signed [DATA_WIDTH-1:0] o_vmem_new,
   output logic                         o_spike
);

   wide_t w_vmem;
   wide_t w_thr;
   wide_t w_leaked;
   wide_t w_integ;

   // Leak never overflows (it moves vmem toward zero), so only the integrate
   // and subtract-reset steps need clamping.
   always_comb begin
      w_vmem     = wide_t'(i_vmem);
      w_thr      = wide_t'(i_threshold);
      w_leaked   = i_leak_enable ? (w_vmem - (w_vmem >>> LEAK_SHIFT)) : w_vmem;
      w_integ    = sat_add(w_leaked, wide_t'(i_weight_sum), DATA_WIDTH);
      o_spike    = (w_integ >= w_thr);
      o_vmem_new = DATA_WIDTH'(w_integ);
      if (o_spike) begin
         o_vmem_new = i_reset_mode ? DATA_WIDTH'(sat_sub(w_integ, w_thr, DATA_WIDTH))
                                   : '0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/neuron_array_pif.sv
// ============================================================================
// Module   : neuron_array_pif
// Purpose  : Array of NUM_NEURONS integrate-and-fire neurons sharing one update
//            datapath. Weights accumulate per neuron while idle; an update
//            command sweeps all neurons once and streams out the results.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module neuron_array_pif
   import neuron_pkg::*;
#(
   parameter int INTEGER_WIDTH   = DEF_INTEGER_WIDTH,
   parameter int DATA_WIDTH_FRAC = DEF_DATA_WIDTH_FRAC,
   parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
   parameter int NUM_NEURONS     = 4,
   parameter int ADDR_WIDTH      = 2,
   parameter int LEAK_SHIFT      = 4
) (
   input  logic               clk,
   input  logic               reset,
   neuron_array_pif_if.slave  pif
);

   state_t                        r_state;
   state_t                        w_state_next;
   logic [ADDR_WIDTH-1:0]         r_idx;
   logic signed [DATA_WIDTH-1:0]  r_vmem [NUM_NEURONS];
   logic signed [DATA_WIDTH-1:0]  r_wsum [NUM_NEURONS];
   logic [NUM_NEURONS-1:0]        r_spike_work;
   logic [NUM_NEURONS-1:0]        w_spike_work_next;
   logic [NUM_NEURONS-1:0]        r_spike_vec;
   logic                          r_spike_valid;
   logic                          r_spike_out;
   logic [ADDR_WIDTH-1:0]         r_spike_addr;
   logic signed [DATA_WIDTH-1:0]  r_vmem_out;
   logic                          r_done;

   logic                          w_busy;
   logic                          w_start;
   logic                          w_sweep;
   logic                          w_last;
   logic                          w_accept;
   logic signed [DATA_WIDTH-1:0]  w_vmem_new;
   logic                          w_spike;

   // Weights land only while idle and only for neurons that exist.
   assign w_accept = pif.weightValid && !w_busy && (int'(pif.weightAddr) < NUM_NEURONS);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode and per-state control strobes.
   always_comb begin
      w_state_next = r_state;
      w_busy       = 1'b1;
      w_start      = 1'b0;
      w_sweep      = 1'b0;
      w_last       = (r_idx == ADDR_WIDTH'(NUM_NEURONS - 1));
      case (r_state)
         ST_IDLE: begin
            w_busy = 1'b0;
            if (pif.updateEnable) begin
               w_start      = 1'b1;
               w_state_next = ST_UPDATE;
            end
         end
         ST_UPDATE: begin
            w_sweep = 1'b1;
            if (w_last) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Sweep index walks 0..NUM_NEURONS-1, one neuron per UPDATE cycle.
   always_ff @(posedge clk) begin
      if (reset || w_start) begin
         r_idx <= '0;
      end else if (w_sweep) begin
         r_idx <= r_idx + 1'b1;
      end
   end

   pif_update_core #(
      .DATA_WIDTH (DATA_WIDTH),
      .LEAK_SHIFT (LEAK_SHIFT)
   ) u_core (
      .i_vmem        (r_vmem[r_idx]),
      .i_weight_sum  (r_wsum[r_idx]),
      .i_threshold   (pif.threshold),
      .i_leak_enable (pif.leakEnable),
      .i_reset_mode  (pif.resetMode),
      .o_vmem_new    (w_vmem_new),
      .o_spike       (w_spike)
   );

   // Spike flags gathered so far this sweep, including the current neuron.
   always_comb begin
      w_spike_work_next        = r_spike_work;
      w_spike_work_next[r_idx] = w_spike;
   end

   // Membrane and weight-sum storage: write back during the sweep, accumulate when idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int n = 0; n < NUM_NEURONS; n++) begin
            r_vmem[n] <= '0;
            r_wsum[n] <= '0;
         end
      end else if (w_sweep) begin
         r_vmem[r_idx] <= w_vmem_new;
         r_wsum[r_idx] <= '0;
      end else if (w_accept) begin
         r_wsum[pif.weightAddr] <= DATA_WIDTH'(sat_add(wide_t'(r_wsum[pif.weightAddr]),
                                                       wide_t'(pif.weightData),
                                                       DATA_WIDTH));
      end
   end

   // Registered result stream; spikeVector only changes as the sweep completes.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_spike_valid <= 1'b0;
         r_spike_out   <= 1'b0;
         r_spike_addr  <= '0;
         r_vmem_out    <= '0;
         r_done        <= 1'b0;
         r_spike_work  <= '0;
         r_spike_vec   <= '0;
      end else begin
         r_spike_valid <= w_sweep;
         r_done        <= w_sweep && w_last;
         if (w_sweep) begin
            r_spike_addr <= r_idx;
            r_spike_out  <= w_spike;
            r_vmem_out   <= w_vmem_new;
            r_spike_work <= w_spike_work_next;
            if (w_last) begin
               r_spike_vec <= w_spike_work_next;
            end
         end
      end
   end

   assign pif.weightReady = !w_busy;
   assign pif.busy        = w_busy;
   assign pif.spikeValid  = r_spike_valid;
   assign pif.spikeAddr   = r_spike_addr;
   assign pif.spikeOut    = r_spike_out;
   assign pif.vmemOut     = r_vmem_out;
   assign pif.spikeVector = r_spike_vec;
   assign pif.done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_neuron_array_pif.sv
// ============================================================================
// Module   : tb_neuron_array_pif
// Purpose  : Self-checking bench for neuron_array_pif against a behavioural
//            model of per-neuron membrane and weight-sum state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_neuron_array_pif;
   import neuron_pkg::*;

   localparam int DW = 16;
   localparam int NN = 4;
   localparam int AW = 2;
   localparam int LS = 4;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   neuron_array_pif_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_NEURONS(NN)) bus ();

   neuron_array_pif #(
      .INTEGER_WIDTH   (16),
      .DATA_WIDTH_FRAC (0),
      .DATA_WIDTH      (DW),
      .NUM_NEURONS     (NN),
      .ADDR_WIDTH      (AW),
      .LEAK_SHIFT      (LS)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .pif   (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int m_vmem [NN];
   int m_wsum [NN];
   int obs_vmem [NN];
   int obs_spike [NN];

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int sat(input int v);
      if (v > int'(DATA_MAX)) return int'(DATA_MAX);
      if (v < int'(DATA_MIN)) return int'(DATA_MIN);
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.weightValid  = 1'b0;
      bus.weightAddr   = '0;
      bus.weightData   = '0;
      bus.updateEnable = 1'b0;
   endtask

   task automatic send_weight(input int a, input int d);
      bus.weightValid = 1'b1;
      bus.weightAddr  = AW'(a);
      bus.weightData  = DW'(d);
      m_wsum[a]       = sat(m_wsum[a] + d);
      tick();
      bus.weightValid = 1'b0;
   endtask

   task automatic drive_junk();
      bus.weightValid  = 1'($urandom_range(0, 1));
      bus.weightAddr   = AW'($urandom_range(0, NN - 1));
      bus.weightData   = DW'($urandom);
      bus.updateEnable = 1'($urandom_range(0, 1));
   endtask

   // One full update: start command, NUM_NEURONS result cycles, return to idle.
   task automatic sweep(input int thr, input bit rm, input bit leak, input bit junk,
                        input bit cw, input int cw_a, input int cw_d);
      int ev [NN];
      int es [NN];
      int evec;
      int l;
      int v;
      bus.threshold  = DW'(thr);
      bus.resetMode  = rm;
      bus.leakEnable = leak;
      if (cw) begin
         bus.weightValid = 1'b1;
         bus.weightAddr  = AW'(cw_a);
         bus.weightData  = DW'(cw_d);
         m_wsum[cw_a]    = sat(m_wsum[cw_a] + cw_d);
      end
      evec = 0;
      for (int i = 0; i < NN; i++) begin
         l = leak ? (m_vmem[i] - (m_vmem[i] >>> LS)) : m_vmem[i];
         v = sat(l + m_wsum[i]);
         es[i] = (v >= thr) ? 1 : 0;
         ev[i] = es[i] != 0 ? (rm ? sat(v - thr) : 0) : v;
         m_vmem[i] = ev[i];
         m_wsum[i] = 0;
         if (es[i] != 0) evec |= (1 << i);
      end
      bus.updateEnable = 1'b1;
      tick();
      idle_inputs();
      check("busy_start", int'(bus.busy), 1);
      check("ready_start", int'(bus.weightReady), 0);
      check("valid_start", int'(bus.spikeValid), 0);
      if (junk) drive_junk();
      for (int i = 0; i < NN; i++) begin
         tick();
         check($sformatf("valid_n%0d", i), int'(bus.spikeValid), 1);
         check($sformatf("addr_n%0d", i), int'(bus.spikeAddr), i);
         check($sformatf("spike_n%0d", i), int'(bus.spikeOut), es[i]);
         check($sformatf("vmem_n%0d", i), int'(bus.vmemOut), ev[i]);
         check($sformatf("done_n%0d", i), int'(bus.done), (i == NN - 1) ? 1 : 0);
         check($sformatf("busy_n%0d", i), int'(bus.busy), 1);
         obs_vmem[i]  = int'(bus.vmemOut);
         obs_spike[i] = int'(bus.spikeOut);
         if (junk) drive_junk();
      end
      check("spikeVector", int'(bus.spikeVector), evec);
      tick();
      idle_inputs();
      check("busy_end", int'(bus.busy), 0);
      check("ready_end", int'(bus.weightReady), 1);
      check("done_end", int'(bus.done), 0);
      check("valid_end", int'(bus.spikeValid), 0);
   endtask

   // Hard stop in case the run ever stalls.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int nw;
      int a;
      int d;
      int thr;
      reset            = 1'b1;
      idle_inputs();
      bus.threshold    = '0;
      bus.resetMode    = 1'b0;
      bus.leakEnable   = 1'b0;
      for (int i = 0; i < NN; i++) begin
         m_vmem[i] = 0;
         m_wsum[i] = 0;
      end
      repeat (3) tick();
      check("rst_busy", int'(bus.busy), 0);
      check("rst_ready", int'(bus.weightReady), 1);
      check("rst_valid", int'(bus.spikeValid), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_vector", int'(bus.spikeVector), 0);
      check("rst_vmemOut", int'(bus.vmemOut), 0);
      check("rst_spikeOut", int'(bus.spikeOut), 0);
      check("rst_spikeAddr", int'(bus.spikeAddr), 0);
      reset = 1'b0;
      tick();

      // Integrate below threshold, then cross it with zeroing reset.
      send_weight(0, 300);
      send_weight(0, 400);
      send_weight(0, 200);
      sweep(1000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      check("t1_vmem0", obs_vmem[0], 900);
      check("t1_spike0", obs_spike[0], 0);
      send_weight(0, 200);
      sweep(1000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      check("t1b_spike0", obs_spike[0], 1);
      check("t1b_vmem0", obs_vmem[0], 0);

      // Subtractive reset.
      send_weight(1, 250);
      sweep(100, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      check("t2_spike1", obs_spike[1], 1);
      check("t2_vmem1", obs_vmem[1], 150);
      check("t2_vector", int'(bus.spikeVector), 2);

      // Leak: 160 - (160 >>> 4) = 150.
      send_weight(2, 160);
      sweep(1000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      check("t3_pre_vmem2", obs_vmem[2], 160);
      sweep(1000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      check("t3_vmem2", obs_vmem[2], 150);
      check("t3_spike2", obs_spike[2], 0);

      // Positive and negative saturation of the weight sum.
      repeat (3) send_weight(3, 28672);
      sweep(32767, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      check("t4_pos_spike3", obs_spike[3], 1);
      check("t4_pos_vmem3", obs_vmem[3], 0);
      send_weight(3, -32768);
      send_weight(3, -32768);
      sweep(32767, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      check("t4_neg_vmem3", obs_vmem[3], -32768);
      check("t4_neg_spike3", obs_spike[3], 0);

      // Traffic while busy is dropped; a weight on the start cycle is included.
      sweep(1000, 1'b0, 1'b0, 1'b1, 1'b1, 0, 77);
      sweep(500, 1'b1, 1'b1, 1'b1, 1'b1, 3, 123);

      // Reset in the middle of a sweep aborts it and clears all state.
      for (int i = 0; i < NN; i++) send_weight(i, 500);
      bus.threshold    = DW'(100);
      bus.updateEnable = 1'b1;
      tick();
      bus.updateEnable = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < NN; i++) begin
         m_vmem[i] = 0;
         m_wsum[i] = 0;
      end
      check("t6_busy", int'(bus.busy), 0);
      check("t6_done", int'(bus.done), 0);
      check("t6_valid", int'(bus.spikeValid), 0);
      check("t6_vector", int'(bus.spikeVector), 0);
      for (int c = 0; c < 5; c++) begin
         tick();
         check($sformatf("t6_nodone_c%0d", c), int'(bus.done), 0);
      end
      sweep(1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      for (int i = 0; i < NN; i++) begin
         check($sformatf("t6_vmem%0d", i), obs_vmem[i], 0);
      end

      // Randomized traffic against the model.
      for (int r = 0; r < 40; r++) begin
         nw = $urandom_range(0, 6);
         for (int k = 0; k < nw; k++) begin
            a = $urandom_range(0, NN - 1);
            if ($urandom_range(0, 3) == 0) d = int'($urandom_range(0, 65535)) - 32768;
            else d = int'($urandom_range(0, 1000)) - 500;
            send_weight(a, d);
            if ($urandom_range(0, 1) == 1) tick();
         end
         if ($urandom_range(0, 2) == 0) thr = int'($urandom_range(0, 65535)) - 32768;
         else thr = int'($urandom_range(0, 1500)) - 200;
         a = $urandom_range(0, NN - 1);
         d = int'($urandom_range(0, 2000)) - 1000;
         sweep(thr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/neuron_array_pif.md
Name: neuron_array_pif

Overview:
- Time-multiplexed array of NUM_NEURONS integrate-and-fire neurons sharing one update datapath; next generation of full_neuron_PIF.
- Accumulates per-neuron signed weight sums from a streaming weight interface.
- On an update command, sweeps every neuron once: optional leak, integrate, threshold, spike, membrane reset.
- Sits between the weight-memory/synapse fetch logic and the spike router of the next layer.

Parameters:
INTEGER_WIDTH, 16, integer bits of vmem/weight
DATA_WIDTH_FRAC, 0, fractional bits
DATA_WIDTH, INTEGER_WIDTH+DATA_WIDTH_FRAC, datapath width (two's complement)
NUM_NEURONS, 4, neurons in the array (>=2)
ADDR_WIDTH, 2, neuron index width, >= clog2(NUM_NEURONS)
LEAK_SHIFT, 4, leak = vmem >>> LEAK_SHIFT (1..DATA_WIDTH-1)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high; clears all state
weightValid  in  1  weightData targets neuron weightAddr this cycle
weightAddr  in  ADDR_WIDTH  target neuron
weightData  in  DATA_WIDTH  signed weight
weightReady  out  1  weights accepted (= !busy)
updateEnable  in  1  start update sweep (sampled in IDLE only)
threshold  in  DATA_WIDTH  signed firing threshold, held stable while busy
resetMode  in  1  0: vmem->0 on spike; 1: vmem->vmem-threshold
leakEnable  in  1  apply leak before integration
busy  out  1  sweep in progress
spikeValid  out  1  spikeAddr/spikeOut/vmemOut valid this cycle
spikeAddr  out  ADDR_WIDTH  neuron just updated
spikeOut  out  1  neuron fired
vmemOut  out  DATA_WIDTH  post-reset membrane value of that neuron
spikeVector  out  NUM_NEURONS  spike flags of last completed sweep
done  out  1  one-cycle pulse, sweep complete

Behaviour:
- Reset: vmem[], weightSum[], spikeVector, spikeValid, spikeOut, spikeAddr, vmemOut, done, busy all 0; FSM to IDLE. Reset mid-sweep aborts with no done pulse.
- FSM: IDLE -> UPDATE on updateEnable; UPDATE holds for NUM_NEURONS cycles, index i=0..N-1; UPDATE -> DONE after i=N-1; DONE -> IDLE unconditionally. busy = (state != IDLE).
- Accumulate (IDLE only): weightValid & weightReady -> weightSum[addr] += weightData, saturating signed (clamp to max/min). weightValid while busy is dropped. weightAddr >= NUM_NEURONS is ignored.
- Same cycle weightValid & updateEnable in IDLE: weight is accumulated and included in the sweep.
- Per neuron i in UPDATE, signed saturating arithmetic:
  - l = leakEnable ? vmem - (vmem >>> LEAK_SHIFT) : vmem
  - v = sat(l + weightSum[i])
  - spike = (v >= threshold)
  - vmem_new = spike ? (resetMode ? sat(v - threshold) : 0) : v
  - weightSum[i] <= 0
- Outputs registered. updateEnable sampled at edge 0 -> neuron i result visible cycle 2+i (spikeValid=1). done=1 and busy=1 in cycle N+1, concurrent with the last spikeValid. spikeVector updated atomically at entry to DONE. Next updateEnable is accepted in cycle N+2.
- updateEnable while busy is ignored. No leak without a sweep; vmem is otherwise static.

Decomposition:
- Shared package neuron_pkg: state enum (IDLE, UPDATE, DONE), saturating add/sub function, DATA_WIDTH min/max constants.
- Sub-module pif_update_core: combinational leak/integrate/threshold/reset for one neuron, reusable by future LIF variants.

Test Plan:
1. Reset, threshold=1000, weights 300,400,200 to neuron 0, update -> neuron 0 vmem=900, spike=0; sweep adds 200 more -> spike=1, vmemOut=0 (resetMode=0).
2. resetMode=1, threshold=100, neuron 1 accumulates 250, update -> spikeOut=1, vmemOut=150, spikeVector=4'b0010.
3. leakEnable=1, LEAK_SHIFT=4, neuron 2 vmem=160, no weights, update -> vmemOut=150, spike=0.
4. Saturation: 3x weight 16'h7000 to neuron 3 -> weightSum clamps to 16'h7FFF; weight -32768 twice clamps to 16'h8000.
5. updateEnable at edge 0 -> spikeValid cycles 2..5 with spikeAddr 0..3, done in cycle 5 only; weightValid during busy is dropped; updateEnable while busy is ignored.
6. reset asserted at sweep cycle 2 -> no done pulse, all vmem/weightSum=0, busy=0 next cycle.
